// File: rtl/inst_boot_loader_pkg.sv
// rtl/inst_boot_loader_pkg.sv - shared loader states, error codes and frame marker
package inst_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;

    localparam logic [7:0] MAGIC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/inst_boot_loader_word_assembler.sv
// rtl/inst_boot_loader_word_assembler.sv - packs payload bytes into words and registers the memory write
module inst_boot_loader_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic [31:0] byte_index,
    input  logic        byte_last,
    output logic [31:0] mem_addr,
    output logic        mem_write_enable,
    output logic [3:0]  mem_write_width,
    output logic [31:0] mem_write_data
);

    logic [31:0] asm_word;
    logic [31:0] word_next;
    logic [1:0]  lane;

    assign lane = byte_index[1:0];

    // Lane 0 starts a fresh word so unused upper lanes of a tail are zero.
    always_comb begin
        word_next = (lane == 2'd0) ? 32'd0 : asm_word;
        word_next[{lane, 3'b000} +: 8] = byte_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            asm_word         <= 32'd0;
            mem_addr         <= 32'd0;
            mem_write_enable <= 1'b0;
            mem_write_width  <= 4'd0;
            mem_write_data   <= 32'd0;
        end else begin
            mem_write_enable <= 1'b0;
            if (byte_valid) begin
                asm_word <= word_next;
                if (lane == 2'd3 || byte_last) begin
                    mem_write_enable <= 1'b1;
                    mem_addr         <= {byte_index[31:2], 2'b00};
                    mem_write_width  <= {2'b00, lane} + 4'd1;
                    mem_write_data   <= word_next;
                end
            end
        end
    end

endmodule

// File: rtl/inst_boot_loader.sv
// rtl/inst_boot_loader.sv - framed byte-stream loader for instruction memory with checksum and core hold
module inst_boot_loader
    import inst_boot_loader_pkg::*;
#(
    parameter int unsigned INST_SIZE_IN_BYTE = 16384,
    parameter logic [7:0]  MAGIC_BYTE        = MAGIC_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic [31:0] mem_addr,
    output logic        mem_write_enable,
    output logic [3:0]  mem_write_width,
    output logic [31:0] mem_write_data,
    output logic        core_hold,
    output logic        load_done,
    output logic        load_error,
    output logic [1:0]  error_code
);

    state_t      state, state_next;
    logic [31:0] byte_count, byte_count_next;
    logic [31:0] len, len_next;
    logic [31:0] len_full;
    logic [1:0]  len_count, len_count_next;
    logic [7:0]  csum, csum_next;
    logic [1:0]  err_q, err_next;
    logic        accept;
    logic        byte_fire;
    logic        byte_last;

    assign rx_ready   = (state == ST_IDLE) || (state == ST_LEN) ||
                        (state == ST_DATA) || (state == ST_CSUM);
    assign accept     = rx_valid && rx_ready;
    assign load_done  = (state == ST_DONE);
    assign load_error = (state == ST_ERROR);
    assign core_hold  = (state != ST_DONE);
    assign error_code = err_q;
    // Length as it stands once the fourth (most significant) byte arrives.
    assign len_full   = {rx_data, len[23:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            byte_count <= 32'd0;
            len        <= 32'd0;
            len_count  <= 2'd0;
            csum       <= 8'd0;
            err_q      <= ERR_NONE;
        end else begin
            state      <= state_next;
            byte_count <= byte_count_next;
            len        <= len_next;
            len_count  <= len_count_next;
            csum       <= csum_next;
            err_q      <= err_next;
        end
    end

    always_comb begin
        state_next      = state;
        byte_count_next = byte_count;
        len_next        = len;
        len_count_next  = len_count;
        csum_next       = csum;
        err_next        = err_q;
        byte_fire       = 1'b0;
        byte_last       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && rx_data == MAGIC_BYTE) begin
                    state_next      = ST_LEN;
                    byte_count_next = 32'd0;
                    csum_next       = 8'd0;
                    len_next        = 32'd0;
                    len_count_next  = 2'd0;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    len_next[{len_count, 3'b000} +: 8] = rx_data;
                    len_count_next = len_count + 2'd1;
                    if (len_count == 2'd3) begin
                        if (len_full > INST_SIZE_IN_BYTE) begin
                            state_next = ST_ERROR;
                            err_next   = ERR_LEN;
                        end else if (len_full == 32'd0) begin
                            state_next = ST_CSUM;
                        end else begin
                            state_next = ST_DATA;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    byte_fire       = 1'b1;
                    byte_last       = (byte_count == len - 32'd1);
                    csum_next       = csum + rx_data;
                    byte_count_next = byte_count + 32'd1;
                    if (byte_last) begin
                        state_next = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    if (rx_data == csum) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_ERROR;
                        err_next   = ERR_CSUM;
                    end
                end
            end
            default: ;
        endcase
    end

    inst_boot_loader_word_assembler u_word_assembler (
        .clk              (clk),
        .reset            (reset),
        .byte_valid       (byte_fire),
        .byte_data        (rx_data),
        .byte_index       (byte_count),
        .byte_last        (byte_last),
        .mem_addr         (mem_addr),
        .mem_write_enable (mem_write_enable),
        .mem_write_width  (mem_write_width),
        .mem_write_data   (mem_write_data)
    );

endmodule

// File: tb/tb_inst_boot_loader.sv
// tb/tb_inst_boot_loader.sv - scoreboard bench for the instruction boot loader
module tb_inst_boot_loader;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [31:0] mem_addr;
    logic        mem_write_enable;
    logic [3:0]  mem_write_width;
    logic [31:0] mem_write_data;
    logic        core_hold;
    logic        load_done;
    logic        load_error;
    logic [1:0]  error_code;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  width;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] tx_q[$];
    int         errors = 0;
    int         checks = 0;

    inst_boot_loader dut (
        .clk              (clk),
        .reset            (reset),
        .rx_valid         (rx_valid),
        .rx_data          (rx_data),
        .rx_ready         (rx_ready),
        .mem_addr         (mem_addr),
        .mem_write_enable (mem_write_enable),
        .mem_write_width  (mem_write_width),
        .mem_write_data   (mem_write_data),
        .core_hold        (core_hold),
        .load_done        (load_done),
        .load_error       (load_error),
        .error_code       (error_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && mem_write_enable) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h width=%0d data=%h, required no write",
                         mem_addr, mem_write_width, mem_write_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_write_width !== e.width || mem_write_data !== e.data) begin
                    errors++;
                    $display("FAIL write: got addr=%h width=%0d data=%h, required addr=%h width=%0d data=%h",
                             mem_addr, mem_write_width, mem_write_data, e.addr, e.width, e.data);
                end
            end
        end
    end

    task automatic push_wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        wr_t e;
        e.addr = a; e.width = w; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic send_all(input int gap_at);
        for (int i = 0; i < tx_q.size(); i++) begin
            if (i == gap_at) begin
                rx_valid = 1'b0;
                @(posedge clk);
                @(negedge clk);
            end
            rx_valid = 1'b1;
            rx_data  = tx_q[i];
            checks++;
            if (rx_ready !== 1'b1) begin
                errors++;
                $display("FAIL rx_ready_in_frame: byte %0d got rx_ready=%b, required 1", i, rx_ready);
            end
            @(posedge clk);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        tx_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_reset_values(input string name);
        logic [74:0] got;
        logic [74:0] req;
        got = {rx_ready, mem_write_enable, mem_addr, mem_write_width, mem_write_data,
               core_hold, load_done, load_error, error_code};
        req = {1'b1, 1'b0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, 2'd0};
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic check_status(input string name, input logic done, input logic err,
                                input logic [1:0] code, input logic hold, input logic ready);
        checks++;
        if ({load_done, load_error, error_code, core_hold, rx_ready} !== {done, err, code, hold, ready}) begin
            errors++;
            $display("FAIL %s: got done=%b err=%b code=%0d hold=%b ready=%b, required done=%b err=%b code=%0d hold=%b ready=%b",
                     name, load_done, load_error, error_code, core_hold, rx_ready,
                     done, err, code, hold, ready);
        end
    endtask

    task automatic finish_frame(input string name);
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_writes_outstanding: got %0d missing writes, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_values("reset_state");

        // 8-byte payload, sum of 11..88 = 0x264 -> checksum 0x64, one idle cycle mid-payload
        push_wr(32'd0, 4'd4, 32'h44332211);
        push_wr(32'd4, 4'd4, 32'h88776655);
        tx_q = '{8'hA5, 8'h08, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                 8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
        send_all(7);
        finish_frame("len8");
        check_status("len8_done", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);

        // 6-byte payload with a two-lane tail
        do_reset();
        push_wr(32'd0, 4'd4, 32'h04030201);
        push_wr(32'd4, 4'd2, 32'h00000605);
        tx_q = '{8'hA5, 8'h06, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                 8'h05, 8'h06, 8'h15};
        send_all(-1);
        finish_frame("len6");
        check_status("len6_done", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);

        // same frame, bad checksum: writes still happen
        do_reset();
        push_wr(32'd0, 4'd4, 32'h04030201);
        push_wr(32'd4, 4'd2, 32'h00000605);
        tx_q = '{8'hA5, 8'h06, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                 8'h05, 8'h06, 8'h16};
        send_all(-1);
        finish_frame("bad_csum");
        check_status("bad_csum_error", 1'b0, 1'b1, 2'd2, 1'b1, 1'b0);
        do_reset();
        check_reset_values("reset_after_writes");

        // LEN = 16385 exceeds capacity
        tx_q = '{8'hA5, 8'h01, 8'h40, 8'h00, 8'h00};
        send_all(-1);
        finish_frame("too_long");
        check_status("too_long_error", 1'b0, 1'b1, 2'd1, 1'b1, 1'b0);

        // garbage before magic, empty payload
        do_reset();
        tx_q = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_all(-1);
        finish_frame("len0");
        check_status("len0_done", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);

        // reset after 3 payload bytes aborts without any write
        do_reset();
        tx_q = '{8'hA5, 8'h06, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03};
        send_all(-1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_reset_values("mid_frame_reset");
        finish_frame("mid_frame");

        // magic value inside payload is data; sum A5+BB+CC+DD+EE = 0x3F7 -> 0xF7
        push_wr(32'd0, 4'd4, 32'hDDCCBBA5);
        push_wr(32'd4, 4'd1, 32'h000000EE);
        tx_q = '{8'hA5, 8'h05, 8'h00, 8'h00, 8'h00, 8'hA5, 8'hBB, 8'hCC, 8'hDD,
                 8'hEE, 8'hF7};
        send_all(-1);
        finish_frame("after_reset");
        check_status("after_reset_done", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
